// File: rtl/spike_event_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spike_event_queue_pkg
// Purpose  : Shared widths and helpers for the spike event queue.
// Revision : 1.0 - initial release
// ============================================================================
package spike_event_queue_pkg;

    localparam int c_ts_w       = 8;
    localparam int c_isi_w      = 8;
    localparam int c_depth      = 4;
    localparam int c_drop_cnt_w = 8;
    localparam int c_rec_w      = c_ts_w + c_isi_w;

    function automatic logic [c_drop_cnt_w-1:0] sat_inc_drop(input logic [c_drop_cnt_w-1:0] v);
        return (v == '1) ? v : v + c_drop_cnt_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_event_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : spike_event_queue_if
// Purpose  : Event-record readout bus with occupancy and loss status.
// Revision : 1.0 - initial release
// ============================================================================
interface spike_event_queue_if #(
    parameter int TS_W  = 8,
    parameter int ISI_W = 8,
    parameter int DEPTH = 4
);
    logic                     out_valid;
    logic                     out_ready;
    logic [TS_W-1:0]          out_timestamp;
    logic [ISI_W-1:0]         out_isi;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic [7:0]               drop_count;

    modport master (
        output out_valid, out_timestamp, out_isi, level, overflow, drop_count,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_timestamp, out_isi, level, overflow, drop_count,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/spike_event_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO; push and pop together on full is legal.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   level
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_level;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({push, pop})
                2'b10:   r_level <= r_level + (c_aw+1)'(1);
                2'b01:   r_level <= r_level - (c_aw+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/spike_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : spike_event_queue
// Purpose  : Turns spike onsets into {timestamp, ISI} records, queued for readout.
// Revision : 1.0 - initial release
// ============================================================================
module spike_event_queue
    import spike_event_queue_pkg::*;
#(
    parameter int TS_W  = c_ts_w,
    parameter int ISI_W = c_isi_w,
    parameter int DEPTH = c_depth
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              spike,
    spike_event_queue_if.master    evq
);
    localparam int c_aw  = $clog2(DEPTH);
    localparam int c_lw  = c_aw + 1;
    localparam int c_rw  = TS_W + ISI_W;
    localparam logic [c_lw-1:0]  c_full    = c_lw'(DEPTH);
    localparam logic [ISI_W-1:0] c_isi_max = '1;

    logic                     r_spike_q;
    logic [TS_W-1:0]          r_ts;
    logic [ISI_W-1:0]         r_isi_cnt;
    logic                     r_overflow;
    logic [c_drop_cnt_w-1:0]  r_drop_count;

    logic                     w_event;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_push;
    logic                     w_drop;
    logic [c_rw-1:0]          w_dout;
    logic [c_lw-1:0]          w_level;

    // A pop frees the head slot in the same edge, so a full queue still accepts.
    always_comb begin
        w_event = spike & ~r_spike_q;
        w_pop   = (w_level != '0) & evq.out_ready;
        w_full  = (w_level == c_full);
        w_push  = w_event & (~w_full | w_pop);
        w_drop  = w_event & w_full & ~w_pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spike_q    <= 1'b0;
            r_ts         <= '0;
            r_isi_cnt    <= c_isi_max;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_spike_q <= spike;
            r_ts      <= r_ts + TS_W'(1);
            if (w_event)
                r_isi_cnt <= ISI_W'(1);
            else if (r_isi_cnt != c_isi_max)
                r_isi_cnt <= r_isi_cnt + ISI_W'(1);
            if (w_drop) begin
                r_overflow   <= 1'b1;
                r_drop_count <= sat_inc_drop(r_drop_count);
            end
        end
    end

    sync_fifo #(
        .WIDTH (c_rw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({r_ts, r_isi_cnt}),
        .dout  (w_dout),
        .level (w_level)
    );

    assign evq.out_valid     = (w_level != '0);
    assign evq.out_timestamp = w_dout[c_rw-1:ISI_W];
    assign evq.out_isi       = w_dout[ISI_W-1:0];
    assign evq.level         = w_level;
    assign evq.overflow      = r_overflow;
    assign evq.drop_count    = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_event_queue
// Purpose  : Directed and random stimulus against a queue-based event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_event_queue;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spike = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    spike_event_queue_if #(.TS_W(8), .ISI_W(8), .DEPTH(4)) evq ();

    spike_event_queue #(.TS_W(8), .ISI_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .spike (spike),
        .evq   (evq)
    );

    always #5 clk = ~clk;

    // Model: absolute edge count since reset, queue of pending records.
    int q_ts[$];
    int q_isi[$];
    int m_t = 0;
    int m_last = -1;
    int m_prev = 0;
    int m_ovf = 0;
    int m_drops = 0;
    bit m_live = 1'b0;

    task automatic model_step();
        bit ev;
        bit pop;
        int isi;
        if (reset) begin
            q_ts.delete();
            q_isi.delete();
            m_t = 0; m_last = -1; m_prev = 0; m_ovf = 0; m_drops = 0;
            m_live = 1'b1;
            return;
        end
        ev  = spike && (m_prev == 0);
        pop = (q_ts.size() != 0) && evq.out_ready;
        if (pop) begin
            void'(q_ts.pop_front());
            void'(q_isi.pop_front());
        end
        if (ev) begin
            isi = (m_last < 0) ? 255 : ((m_t - m_last > 255) ? 255 : m_t - m_last);
            if (q_ts.size() < 4) begin
                q_ts.push_back(m_t % 256);
                q_isi.push_back(isi);
            end else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            m_last = m_t;
        end
        m_prev = spike ? 1 : 0;
        m_t++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(evq.out_valid), 32'(q_ts.size() != 0));
        check("level", 32'(evq.level), q_ts.size());
        check("overflow", 32'(evq.overflow), m_ovf);
        check("drop_count", 32'(evq.drop_count), m_drops);
        if (q_ts.size() != 0) begin
            check("out_timestamp", 32'(evq.out_timestamp), q_ts[0]);
            check("out_isi", 32'(evq.out_isi), q_isi[0]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) compare_all();
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input logic spk);
        reset = 1'b1;
        spike = spk;
        step(2);
        reset = 1'b0;
    endtask

    task automatic pulse();
        spike = 1'b1;
        step();
        spike = 1'b0;
        step();
    endtask

    initial begin
        evq.out_ready = 1'b1;

        // Reset with spike held high; spike still high after release is an event at ts 0.
        do_reset(1'b1);
        step(0);
        reset = 1'b1;
        step();
        check("rst_valid", 32'(evq.out_valid), 0);
        check("rst_level", 32'(evq.level), 0);
        check("rst_overflow", 32'(evq.overflow), 0);
        check("rst_drops", 32'(evq.drop_count), 0);
        evq.out_ready = 1'b0;
        reset = 1'b0;
        step();
        spike = 1'b0;
        check("first_edge_ts", 32'(evq.out_timestamp), 0);
        check("first_edge_isi", 32'(evq.out_isi), 255);

        // Single pulse sampled at ts=5.
        do_reset(1'b0);
        evq.out_ready = 1'b1;
        step(5);
        spike = 1'b1;
        step();
        spike = 1'b0;
        check("p2_valid", 32'(evq.out_valid), 1);
        check("p2_ts", 32'(evq.out_timestamp), 5);
        check("p2_isi", 32'(evq.out_isi), 255);
        step();
        check("p2_valid_once", 32'(evq.out_valid), 0);

        // Held-high spike yields one event; second onset 7 cycles later.
        do_reset(1'b0);
        evq.out_ready = 1'b0;
        step(10);
        spike = 1'b1;
        step(5);
        spike = 1'b0;
        step(2);
        spike = 1'b1;
        step(3);
        spike = 1'b0;
        step(2);
        check("p3_level", 32'(evq.level), 2);
        check("p3_head_ts", 32'(evq.out_timestamp), 10);
        evq.out_ready = 1'b1;
        step();
        evq.out_ready = 1'b0;
        check("p3_second_ts", 32'(evq.out_timestamp), 17);
        check("p3_second_isi", 32'(evq.out_isi), 7);

        // Overflow: six pulses into four entries.
        do_reset(1'b0);
        evq.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse();
        check("p4_level", 32'(evq.level), 4);
        check("p4_overflow", 32'(evq.overflow), 1);
        check("p4_drops", 32'(evq.drop_count), 2);
        evq.out_ready = 1'b1;
        step(4);
        check("p4_drained", 32'(evq.level), 0);
        check("p4_sticky", 32'(evq.overflow), 1);

        // Full queue, pop and onset on the same edge.
        do_reset(1'b0);
        evq.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse();
        spike = 1'b1;
        evq.out_ready = 1'b1;
        step();
        spike = 1'b0;
        evq.out_ready = 1'b0;
        check("p5_level", 32'(evq.level), 4);
        check("p5_drops", 32'(evq.drop_count), 0);
        evq.out_ready = 1'b1;
        step(3);
        check("p5_last_ts", 32'(evq.out_timestamp), 8);
        step();

        // Timestamp wrap: onsets at ts 255 and ts 2.
        do_reset(1'b0);
        evq.out_ready = 1'b0;
        step(255);
        spike = 1'b1;
        step();
        spike = 1'b0;
        step(2);
        spike = 1'b1;
        step();
        spike = 1'b0;
        evq.out_ready = 1'b1;
        step();
        evq.out_ready = 1'b0;
        check("p6_wrap_ts", 32'(evq.out_timestamp), 2);
        check("p6_wrap_isi", 32'(evq.out_isi), 3);

        // Long idle gap saturates the interval.
        do_reset(1'b1);
        evq.out_ready = 1'b0;
        step();
        spike = 1'b0;
        step(300);
        spike = 1'b1;
        step();
        spike = 1'b0;
        evq.out_ready = 1'b1;
        step();
        check("p6_sat_isi", 32'(evq.out_isi), 255);

        // Randomized traffic with occasional mid-run resets.
        do_reset(1'b0);
        for (int i = 0; i < 4000; i++) begin
            spike = ($urandom_range(0, 2) == 0);
            evq.out_ready = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        spike = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
